// File: rtl/reorder_buffer.sv
// In-order completion ROB: tracks dispatched instructions, takes out-of-order finishes, retires up to two per cycle.
// Optional macro ROB_FLUSH_EN adds a synchronous flush input that empties the buffer.
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ROB_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             disp_en_A,
  input  logic             disp_en_B,
  input  logic             disp_wr_A,
  input  logic             disp_wr_B,
  input  logic [4:0]       disp_rd_A,
  input  logic [4:0]       disp_rd_B,
  output logic [TAG_W-1:0] disp_tag_A,
  output logic [TAG_W-1:0] disp_tag_B,
  output logic             disp_stall,
  input  logic             fin_en_A,
  input  logic             fin_en_B,
  input  logic [TAG_W-1:0] fin_tag_A,
  input  logic [TAG_W-1:0] fin_tag_B,
  output logic             updateEnA,
  output logic             updateEnB,
  output logic [4:0]       updateAddrA,
  output logic [4:0]       updateAddrB,
  output logic [1:0]       retire_count,
  output logic [TAG_W:0]   rob_count
);

  logic             r_valid [DEPTH];
  logic             r_done  [DEPTH];
  logic             r_wr    [DEPTH];
  logic [4:0]       r_rd    [DEPTH];
  logic [TAG_W-1:0] r_head, r_tail;
  logic [TAG_W:0]   r_count;
  logic             r_upd_en_a, r_upd_en_b;
  logic [4:0]       r_upd_addr_a, r_upd_addr_b;
  logic [1:0]       r_retire_count;

  logic             w_valid_next [DEPTH];
  logic             w_done_next  [DEPTH];
  logic             w_flush;
  logic [1:0]       w_n, w_acc_n, w_ret;
  logic [TAG_W:0]   w_free;
  logic             w_stall, w_acc_a, w_acc_b;
  logic [TAG_W-1:0] w_head1, w_tag_a, w_tag_b;
  logic             w_r0, w_r1;

`ifdef ROB_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_n     = {1'b0, disp_en_A} + {1'b0, disp_en_B};
  assign w_free  = (TAG_W+1)'(DEPTH) - r_count;
  assign w_stall = w_flush | ((TAG_W+1)'(w_n) > w_free);
  assign w_acc_a = disp_en_A & ~w_stall;
  assign w_acc_b = disp_en_B & ~w_stall;
  assign w_acc_n = w_stall ? 2'd0 : w_n;
  assign w_tag_a = r_tail;
  assign w_tag_b = r_tail + TAG_W'(disp_en_A);

  assign w_head1 = r_head + TAG_W'(1);
  assign w_r0    = r_valid[r_head] & r_done[r_head];
  assign w_r1    = w_r0 & r_valid[w_head1] & r_done[w_head1];
  assign w_ret   = {1'b0, w_r0} + {1'b0, w_r1};

  // Retire clears first, then dispatch fills, then finish marks only pre-edge valid survivors.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_valid_next[i] = r_valid[i];
      w_done_next[i]  = r_done[i];
      if ((w_r0 && r_head == TAG_W'(i)) || (w_r1 && w_head1 == TAG_W'(i))) begin
        w_valid_next[i] = 1'b0;
        w_done_next[i]  = 1'b0;
      end else if ((w_acc_a && w_tag_a == TAG_W'(i)) || (w_acc_b && w_tag_b == TAG_W'(i))) begin
        w_valid_next[i] = 1'b1;
        w_done_next[i]  = 1'b0;
      end else if (r_valid[i] && ((fin_en_A && fin_tag_A == TAG_W'(i)) ||
                                  (fin_en_B && fin_tag_B == TAG_W'(i)))) begin
        w_done_next[i] = 1'b1;
      end
      if (w_flush) begin
        w_valid_next[i] = 1'b0;
        w_done_next[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_done[i]  <= 1'b0;
        r_wr[i]    <= 1'b0;
        r_rd[i]    <= 5'd0;
      end
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_upd_en_a     <= 1'b0;
      r_upd_en_b     <= 1'b0;
      r_upd_addr_a   <= 5'd0;
      r_upd_addr_b   <= 5'd0;
      r_retire_count <= 2'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= w_valid_next[i];
        r_done[i]  <= w_done_next[i];
      end
      if (w_acc_a) begin
        r_wr[w_tag_a] <= disp_wr_A;
        r_rd[w_tag_a] <= disp_rd_A;
      end
      if (w_acc_b) begin
        r_wr[w_tag_b] <= disp_wr_B;
        r_rd[w_tag_b] <= disp_rd_B;
      end
      if (w_flush) begin
        r_head         <= '0;
        r_tail         <= '0;
        r_count        <= '0;
        r_upd_en_a     <= 1'b0;
        r_upd_en_b     <= 1'b0;
        r_upd_addr_a   <= 5'd0;
        r_upd_addr_b   <= 5'd0;
        r_retire_count <= 2'd0;
      end else begin
        r_head         <= r_head + TAG_W'(w_ret);
        r_tail         <= r_tail + TAG_W'(w_acc_n);
        r_count        <= r_count + (TAG_W+1)'(w_acc_n) - (TAG_W+1)'(w_ret);
        r_upd_en_a     <= w_r0 & r_wr[r_head];
        r_upd_en_b     <= w_r1 & r_wr[w_head1];
        r_upd_addr_a   <= (w_r0 & r_wr[r_head])  ? r_rd[r_head]  : 5'd0;
        r_upd_addr_b   <= (w_r1 & r_wr[w_head1]) ? r_rd[w_head1] : 5'd0;
        r_retire_count <= w_ret;
      end
    end
  end

  assign disp_tag_A   = w_tag_a;
  assign disp_tag_B   = w_tag_b;
  assign disp_stall   = w_stall;
  assign updateEnA    = r_upd_en_a;
  assign updateEnB    = r_upd_en_b;
  assign updateAddrA  = r_upd_addr_a;
  assign updateAddrB  = r_upd_addr_b;
  assign retire_count = r_retire_count;
  assign rob_count    = r_count;

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order completion unit paired with the rename register file. Dispatched instructions are tracked in program order. Execution-finish reports are accepted out of order. Up to two of the oldest finished instructions retire per cycle. For each retired GPR writer, the block issues the ARF update command (`updateEnA/B`, `updateAddrA/B`) that commits the RRF value to the ARF and frees the rename entry.

## Interface
Parameters:
- `DEPTH`, 8: ROB entries; must equal 2^`TAG_W`, and equals RRF depth.
- `TAG_W`, 3: ROB index width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `disp_en_A`  in  1  dispatch request, older instruction.
- `disp_en_B`  in  1  dispatch request, younger instruction.
- `disp_wr_A`  in  1  A writes a GPR.
- `disp_wr_B`  in  1  B writes a GPR.
- `disp_rd_A`  in  5  A destination register.
- `disp_rd_B`  in  5  B destination register.
- `disp_tag_A`  out  `TAG_W`  ROB index assigned to A; combinational.
- `disp_tag_B`  out  `TAG_W`  ROB index assigned to B; combinational.
- `disp_stall`  out  1  dispatch refused this cycle; combinational.
- `fin_en_A`  in  1  execution-finish report, port A.
- `fin_en_B`  in  1  execution-finish report, port B.
- `fin_tag_A`  in  `TAG_W`  ROB index of the finished instruction, port A.
- `fin_tag_B`  in  `TAG_W`  ROB index of the finished instruction, port B.
- `updateEnA`  out  1  ARF update, older retiree; registered.
- `updateEnB`  out  1  ARF update, younger retiree; registered.
- `updateAddrA`  out  5  ARF update address, older retiree; registered.
- `updateAddrB`  out  5  ARF update address, younger retiree; registered.
- `retire_count`  out  2  instructions retired at the last edge: 0, 1 or 2; registered.
- `rob_count`  out  `TAG_W`+1  occupied entries, 0..`DEPTH`; registered.

## Operation
- **Storage:** circular buffer with `head` (oldest) and `tail` (next free). Pointers are `TAG_W` bits and wrap modulo `DEPTH`. A separate `count` register distinguishes full from empty.
- **Entry fields:** `valid`, `done`, `wr`, `rd[4:0]`.
- **Dispatch request count:** n = `disp_en_A` + `disp_en_B`.
- **Stall rule:** `disp_stall` = (n > `DEPTH` − `count`). When stalled, neither request is accepted; partial acceptance never occurs.
- **Tag assignment:**
  - `disp_tag_A` = `tail`.
  - `disp_tag_B` = `tail` + `disp_en_A`, so B alone takes `tail`.
- **Accepted dispatch:**
  - Entries are written with `valid`=1, `done`=0, and the `wr`/`rd` inputs.
  - `tail` advances by n.
- **Finish reports:**
  - `fin_en_X` sets `done[fin_tag_X]` only if that entry is already `valid`; otherwise the report is ignored.
  - Both ports may name any entries. If both name the same tag, the entry is marked once.
- **Retire, from registered state:**
  - r0 = `valid[head]` & `done[head]`.
  - r1 = r0 & `valid[head+1]` & `done[head+1]`.
  - Retired entries clear `valid`/`done`; `head` advances by r0+r1.
- **Update command:**
  - `updateEnA` <= r0 & `wr[head]`; `updateAddrA` <= `rd[head]` when enabled, else 0.
  - `updateEnB` <= r1 & `wr[head+1]`; `updateAddrB` <= `rd[head+1]` when enabled, else 0.
  - Non-writers (`wr`=0) retire silently but still count toward `retire_count`.
- **Occupancy:** `count` <= `count` + accepted − retired. Dispatch and retire in the same edge are legal.
- **Register-file contract:** at most one in-flight writer per architectural register. The ROB does not check this.

## Timing
- **Reset values:**
  - Pointers = 0, `count` = 0, all `valid`/`done` = 0.
  - `updateEnA/B` = 0, `updateAddrA/B` = 0, `retire_count` = 0, `rob_count` = 0.
  - `disp_stall` = 0 while n ≤ 8.
- **Reset mid-operation:** all in-flight entries are discarded immediately, asynchronously.
- **Finish-to-update latency:**
  - `fin_en` sampled at edge N sets `done`.
  - If the entry is at `head`, retire occurs at edge N+1, and `updateEn` is high during cycle N+1→N+2.
  - The register file commits at edge N+2.
- **Same-edge cases:**
  - Finish and retire of the same entry at one edge is impossible, because retire reads pre-edge `done`.
  - Finish naming an entry dispatched at the same edge is ignored.
- **Update pulse width:** `updateEn` pulses last one cycle per retirement. Back-to-back retires give continuous pulses with new addresses.
- **Full:** `count` = 8 stalls any dispatch.
- **One free entry:** `count` = 7 with a dual request stalls both. `count` = 7 with a single request is accepted.
- **Wrap:** `head` = 7 retiring two uses entries 7 and 0; `tail` = 7 dispatching two writes entries 7 and 0.

## Configuration
- **`ROB_FLUSH_EN` defined:** adds input `flush` (1 bit).
  - When `flush` is sampled high, all entries are invalidated, `head` = `tail` = 0 and `count` = 0.
  - `updateEnA/B` and `retire_count` are 0 next cycle.
  - `flush` overrides dispatch, finish and retire at the same edge; `disp_stall` is forced high while `flush` = 1.
- **`ROB_FLUSH_EN` undefined:** no `flush` port. Entries leave only by retirement or reset.

## Test plan
- **Single writer:** dispatch A (`wr`=1, `rd`=5) → `disp_tag_A`=0. Finish tag 0 two cycles later → next cycle `updateEnA`=1, `updateAddrA`=5, `retire_count`=1, `rob_count`=0.
- **Out-of-order finish:** dual dispatch `rd` 3/4 (tags 0/1). Finish tag 1 first → no update. Then finish tag 0 → one cycle with `updateEnA`=1/addr 3 and `updateEnB`=1/addr 4, `retire_count`=2.
- **Fill and stall:** dispatch 8 entries → `rob_count`=8 and `disp_stall`=1 for a single request, state unchanged. At `count` = 7, a dual request stalls and a single request is accepted.
- **Wrap-around:** cycle so `head` = `tail` = 6. Dispatch 4 entries → tags 6, 7, 0, 1. Finish all → retires in pairs (6, 7) then (0, 1), addresses in dispatch order.
- **Non-writer and invalid finish:** dispatch `wr`=0 → its retire gives `updateEnA`=0, `updateAddrA`=0, `retire_count`=1. A finish on an empty tag changes nothing.
- **Reset / flush mid-flight:** with 5 entries in flight, pulse `rst_n` low → all outputs are at reset values immediately. With `ROB_FLUSH_EN`, `flush` alongside a finish gives `rob_count`=0 and no update.
